cell_entry_sequencer: RTL and testbench
=======================================

Name: cell_entry_sequencer

Overview:
Sequences all player edits to the 9x9 sudoku board. It accepts decoded key commands over a valid/ready handshake and handles three kinds of work. Cursor moves complete in one cycle. Digit entry and clear are multi-cycle read-check-write transactions against the board RAM, and fixed cells are never written. It also tracks the number of filled cells and raises board_full at 81. It sits between the keyboard decoder and the board memory, and supplies the cursor to the VGA renderer.

Parameters:
GRID_MAX, 8, highest row/column index; the cursor saturates at 0 and at GRID_MAX.
CELLS, 81, number of board cells; also the board_full threshold.

Ports:
clock  in  1  system clock, all logic on posedge
reset_n  in  1  reset, asynchronous, active-low
key_valid  in  1  command present
key_ready  out  1  block can accept a command; high only in IDLE
key_code  in  4  1=W row+1, 2=D col-1, 3=S row-1, 4=A col+1, 5=write digit, 6=clear cell, others=no-op
key_digit  in  4  digit for code 5; legal range 1..9
count_load  in  1  load filled_count from count_init; honoured only in IDLE
count_init  in  7  filled count after a puzzle load (givens)
cell_addr  out  7  cursor_i*9 + cursor_j, combinational from the registered cursor
rd_en  out  1  one-cycle board read strobe
rd_value  in  4  cell value, valid the cycle after rd_en; 0 = empty
rd_fixed  in  1  cell-is-given flag, same timing as rd_value
wr_req  out  1  write request, held until wr_ready
wr_ready  in  1  memory accepts the write
wr_data  out  4  value to write (0 for clear)
cursor_i, cursor_j  out  4 each  current cursor row and column
busy  out  1  high whenever state != IDLE
reject  out  1  one-cycle pulse when an edit is refused
filled_count  out  7  number of non-zero cells
board_full  out  1  filled_count == CELLS

Behaviour:
- Reset (async assert, sync release): state=IDLE, cursor 0/0, filled_count=0. rd_en, wr_req, wr_data, reject all 0. key_ready=1 after release.
- Accept condition: key_valid & key_ready in IDLE, at cycle T.
- Moves (codes 1-4):
  - Cursor updates at the T edge with saturation: code 1 does nothing at row 8, code 3 at row 0, code 2 at col 0, code 4 at col 8.
  - State stays IDLE.
- No-op codes: accepted and ignored.
- Code 5 with key_digit 0 or >9: reject pulses at T+1; no RAM access.
- FSM for codes 5/6: IDLE -> RD -> CHK -> (WR | IDLE) -> IDLE.
  - RD (T+1): rd_en=1 for exactly one cycle; the operation and digit are latched at T.
  - CHK (T+2): sample rd_value and rd_fixed, then decide:
    - rd_fixed=1: reject pulse at T+3, go to IDLE.
    - New value equals rd_value: go to IDLE with no write and no reject.
    - Otherwise: go to WR.
  - WR (from T+3): wr_req=1 and wr_data stable until the cycle where wr_ready=1; that cycle completes the handshake. The next cycle is IDLE.
  - Minimum transaction length: 4 cycles, including the accept cycle.
- filled_count update, on the handshake edge only:
  - Old value 0 and new value non-zero: +1.
  - Old value non-zero and new value 0: -1.
  - Otherwise: unchanged.
  - Never wraps; the update is blocked when count=CELLS (+1) or count=0 (-1).
- count_load in IDLE has priority over a key accept in the same cycle: the count loads and key_ready is 0 that cycle.
- Cursor and cell_addr are frozen while busy, so the address is stable across the transaction.
- Reset mid-transaction: wr_req drops immediately (async) and no count update occurs. The memory must tolerate an abandoned request.
- board_full is combinational from filled_count.

Decomposition:
- sudoku_pkg:
  - key_code_e enum: KEY_W=1, KEY_D=2, KEY_S=3, KEY_A=4, KEY_DIGIT=5, KEY_CLEAR=6.
  - seq_state_e enum: IDLE, RD, CHK, WR.
  - GRID_MAX and CELLS constants.
- Sub-module grid_cursor holds the saturating cursor registers and the move decode. Its inputs are a move strobe and the code; its outputs are cursor_i and cursor_j.

Test Plan:
1. Reset, then 10 x code 1, then 10 x code 4 -> cursor_i=8, cursor_j=8, cell_addr=80; code 3 then code 2 -> 7/7, cell_addr=70.
2. Cursor at 0/0, code 5 digit 7, memory returns rd_value=0, rd_fixed=0, wr_ready high immediately -> rd_en at T+1, wr_req with wr_data=7 at T+3, filled_count 0->1, key_ready high again at T+4.
3. Same cell, rd_fixed=1, code 6 -> no wr_req, reject pulses exactly at T+3, filled_count unchanged.
4. Cell holds 5, code 5 digit 5 -> no write and no reject; then code 6 with wr_ready delayed 3 cycles -> wr_req held 4 cycles with wr_data=0, filled_count -1 after the handshake.
5. count_load with count_init=80, then digit 3 into an empty cell -> filled_count=81, board_full=1; a further write of 4 over that cell leaves the count at 81.
6. reset_n asserted while wr_req=1 -> wr_req 0 the same cycle, FSM in IDLE, cursor 0/0, count 0; code 5 digit 0 after release -> reject at T+1, no rd_en.

Source files
------------

// File: rtl/sudoku_pkg.sv
// ---------------------------------------------------------------------------
// sudoku_pkg
// Shared types and constants for the sudoku board editing path.
//   key_code_e  : decoded keyboard commands delivered to the sequencer
//   seq_state_e : states of the read-check-write edit sequencer
//   GRID_MAX    : highest row/column index of the 9x9 board
//   CELLS       : number of board cells (also the "board full" count)
//   cell_index  : row/column to linear board address (row*9 + col)
// ---------------------------------------------------------------------------
package sudoku_pkg;

  localparam int GRID_MAX = 8;
  localparam int CELLS    = 81;

  typedef enum logic [3:0] {
    KEY_W     = 4'd1,
    KEY_D     = 4'd2,
    KEY_S     = 4'd3,
    KEY_A     = 4'd4,
    KEY_DIGIT = 4'd5,
    KEY_CLEAR = 4'd6
  } key_code_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CHK,
    WR
  } seq_state_e;

  function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    return ({3'd0, row} * 7'd9) + {3'd0, col};
  endfunction

endpackage

// File: rtl/cell_entry_sequencer_if.sv
// ---------------------------------------------------------------------------
// cell_entry_sequencer_if
// Bundles the key-command handshake and the board RAM bus of the sequencer.
//   key_valid/key_ready/key_code/key_digit : command handshake from decoder
//   cell_addr                              : board address of the cursor
//   rd_en -> rd_value/rd_fixed             : one-cycle read, data next cycle
//   wr_req/wr_ready/wr_data                : write request held until ready
// master: the sequencer side; slave: keyboard decoder plus board memory.
// ---------------------------------------------------------------------------
interface cell_entry_sequencer_if;

  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic [3:0] key_digit;
  logic [6:0] cell_addr;
  logic       rd_en;
  logic [3:0] rd_value;
  logic       rd_fixed;
  logic       wr_req;
  logic       wr_ready;
  logic [3:0] wr_data;

  modport master (
    input  key_valid, key_code, key_digit, rd_value, rd_fixed, wr_ready,
    output key_ready, cell_addr, rd_en, wr_req, wr_data
  );

  modport slave (
    output key_valid, key_code, key_digit, rd_value, rd_fixed, wr_ready,
    input  key_ready, cell_addr, rd_en, wr_req, wr_data
  );

endinterface

// File: rtl/grid_cursor.sv
// ---------------------------------------------------------------------------
// grid_cursor
// Saturating board cursor. Moves only on an accepted command (move_en) whose
// code is one of the four move keys; every other code leaves it alone.
//   clock, reset_n : clock and asynchronous active-low reset
//   move_en        : a key command was accepted this cycle
//   key_code       : the accepted command code
//   cursor_i/j     : current row / column, held in 0..GRID_MAX
// ---------------------------------------------------------------------------
module grid_cursor
  import sudoku_pkg::*;
#(
  parameter int GRID_MAX = sudoku_pkg::GRID_MAX
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       move_en,
  input  logic [3:0] key_code,
  output logic [3:0] cursor_i,
  output logic [3:0] cursor_j
);

  localparam logic [3:0] EDGE = 4'(GRID_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cursor_i <= 4'd0;
      cursor_j <= 4'd0;
    end else if (move_en) begin
      case (key_code)
        KEY_W:   if (cursor_i != EDGE) cursor_i <= cursor_i + 4'd1;
        KEY_S:   if (cursor_i != 4'd0) cursor_i <= cursor_i - 4'd1;
        KEY_A:   if (cursor_j != EDGE) cursor_j <= cursor_j + 4'd1;
        KEY_D:   if (cursor_j != 4'd0) cursor_j <= cursor_j - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cell_entry_sequencer.sv
// ---------------------------------------------------------------------------
// cell_entry_sequencer
// Applies player edits to the sudoku board. Moves finish in the accept cycle;
// digit entry and clear run read -> check -> (write) against the board RAM.
// Given (fixed) cells are never written. Tracks the filled-cell count.
//   clock, reset_n   : clock and asynchronous active-low reset
//   bus              : key handshake + board RAM bus (master side)
//   count_load/init  : load filled_count after a puzzle load (IDLE only)
//   cursor_i/j       : cursor for the renderer
//   busy             : an edit transaction is in flight
//   reject           : one-cycle pulse when an edit is refused
//   filled_count     : number of non-empty cells
//   board_full       : filled_count has reached CELLS
// ---------------------------------------------------------------------------
module cell_entry_sequencer
  import sudoku_pkg::*;
#(
  parameter int GRID_MAX = sudoku_pkg::GRID_MAX,
  parameter int CELLS    = sudoku_pkg::CELLS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  cell_entry_sequencer_if.master bus,
  input  logic                  count_load,
  input  logic [6:0]            count_init,
  output logic [3:0]            cursor_i,
  output logic [3:0]            cursor_j,
  output logic                  busy,
  output logic                  reject,
  output logic [6:0]            filled_count,
  output logic                  board_full
);

  localparam logic [6:0] FULL = 7'(CELLS);

  seq_state_e state_q, state_d;
  logic [3:0] new_val_q, new_val_d;
  logic [3:0] old_val_q, old_val_d;
  logic       reject_q, reject_d;
  logic [6:0] count_q, count_d;
  logic       accept;
  logic       digit_ok;

  // Count follows empty<->filled transitions only and never wraps.
  function automatic logic [6:0] count_step(input logic [6:0] cnt,
                                            input logic [3:0] old_v,
                                            input logic [3:0] new_v);
    if ((old_v == 4'd0) && (new_v != 4'd0) && (cnt != FULL))
      return cnt + 7'd1;
    if ((old_v != 4'd0) && (new_v == 4'd0) && (cnt != 7'd0))
      return cnt - 7'd1;
    return cnt;
  endfunction

  // count_load wins over a key in the same cycle, so drop ready then.
  assign bus.key_ready = (state_q == IDLE) && !count_load;
  assign accept        = bus.key_valid && bus.key_ready;
  assign digit_ok      = (bus.key_digit != 4'd0) && (bus.key_digit <= 4'd9);

  // Moves are only accepted in IDLE, so the address is frozen while busy.
  grid_cursor #(.GRID_MAX(GRID_MAX)) u_cursor (
    .clock    (clock),
    .reset_n  (reset_n),
    .move_en  (accept),
    .key_code (bus.key_code),
    .cursor_i (cursor_i),
    .cursor_j (cursor_j)
  );

  assign bus.cell_addr = cell_index(cursor_i, cursor_j);
  // Request/strobe decode straight from state so reset drops them at once.
  assign bus.rd_en     = (state_q == RD);
  assign bus.wr_req    = (state_q == WR);
  assign bus.wr_data   = (state_q == WR) ? new_val_q : 4'd0;

  assign busy          = (state_q != IDLE);
  assign reject        = reject_q;
  assign filled_count  = count_q;
  assign board_full    = (count_q == FULL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    new_val_d = new_val_q;
    old_val_d = old_val_q;
    reject_d  = 1'b0;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (count_load) begin
          count_d = count_init;
        end else if (accept) begin
          if (bus.key_code == KEY_DIGIT) begin
            if (digit_ok) begin
              new_val_d = bus.key_digit;
              state_d   = RD;
            end else begin
              reject_d = 1'b1;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            new_val_d = 4'd0;
            state_d   = RD;
          end
        end
      end
      RD: state_d = CHK;
      CHK: begin
        old_val_d = bus.rd_value;
        if (bus.rd_fixed) begin
          reject_d = 1'b1;
          state_d  = IDLE;
        end else if (bus.rd_value == new_val_q) begin
          state_d = IDLE;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        if (bus.wr_ready) begin
          count_d = count_step(count_q, old_val_q, new_val_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      new_val_q <= 4'd0;
      old_val_q <= 4'd0;
      reject_q  <= 1'b0;
      count_q   <= 7'd0;
    end else begin
      new_val_q <= new_val_d;
      old_val_q <= old_val_d;
      reject_q  <= reject_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_cell_entry_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cell_entry_sequencer
// Directed bench for cell_entry_sequencer with a small board memory model.
// ---------------------------------------------------------------------------
module tb_cell_entry_sequencer;
  import sudoku_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       count_load;
  logic [6:0] count_init;
  logic [3:0] cursor_i;
  logic [3:0] cursor_j;
  logic       busy;
  logic       reject;
  logic [6:0] filled_count;
  logic       board_full;

  cell_entry_sequencer_if bus ();

  cell_entry_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .count_load   (count_load),
    .count_init   (count_init),
    .cursor_i     (cursor_i),
    .cursor_j     (cursor_j),
    .busy         (busy),
    .reject       (reject),
    .filled_count (filled_count),
    .board_full   (board_full)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Board memory model: registered read, write-ready after wr_delay cycles.
  logic [3:0] mem_val   [0:80];
  logic       mem_fixed [0:80];
  logic [3:0] rd_value_m = 4'd0;
  logic       rd_fixed_m = 1'b0;
  int         wr_delay = 0;
  int         wait_cnt = 0;

  always @(posedge clock) begin
    if (bus.rd_en) begin
      rd_value_m <= mem_val[bus.cell_addr];
      rd_fixed_m <= mem_fixed[bus.cell_addr];
    end
  end

  always @(posedge clock) begin
    if (!bus.wr_req)           wait_cnt <= 0;
    else if (wait_cnt < wr_delay) wait_cnt <= wait_cnt + 1;
  end

  assign bus.rd_value = rd_value_m;
  assign bus.rd_fixed = rd_fixed_m;
  assign bus.wr_ready = bus.wr_req && (wait_cnt >= wr_delay);

  // Event monitor, sampled on the falling edge.
  int   cyc = 0;
  int   rd_cnt = 0, rd_cyc = -1;
  int   rej_cnt = 0, rej_cyc = -1;
  int   wr_cnt = 0, wr_first_cyc = -1, wr_first_data = -1;
  logic wr_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    wr_prev <= bus.wr_req;
    if (bus.rd_en) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
    end
    if (reject) begin
      rej_cnt <= rej_cnt + 1;
      rej_cyc <= cyc;
    end
    if (bus.wr_req) begin
      wr_cnt <= wr_cnt + 1;
      if (!wr_prev) begin
        wr_first_cyc  <= cyc;
        wr_first_data <= int'(bus.wr_data);
      end
    end
  end

  int t_acc;
  int r0, w0, j0;

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic send_key(input logic [3:0] code, input logic [3:0] digit);
    step();
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    bus.key_digit = digit;
    t_acc = cyc;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && busy; k++) step();
    if (busy) check_val("idle_timeout", 1, 0);
  endtask

  task automatic snap();
    r0 = rd_cnt;
    w0 = wr_cnt;
    j0 = rej_cnt;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 81; a++) begin
      mem_val[a]   = 4'd0;
      mem_fixed[a] = 1'b0;
    end
    reset_n       = 1'b0;
    count_load    = 1'b0;
    count_init    = 7'd0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.key_digit = 4'd0;
    step();
    step();
    check_val("rst_wr_req", int'(bus.wr_req), 0);
    check_val("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    step();

    // ---- 1: reset state, cursor saturation, no-ops ----
    check_val("rst_cursor_i", int'(cursor_i), 0);
    check_val("rst_cursor_j", int'(cursor_j), 0);
    check_val("rst_count", int'(filled_count), 0);
    check_val("rst_key_ready", int'(bus.key_ready), 1);
    check_val("rst_rd_en", int'(bus.rd_en), 0);
    check_val("rst_reject", int'(reject), 0);
    check_val("rst_wr_data", int'(bus.wr_data), 0);
    check_val("rst_full", int'(board_full), 0);

    for (int k = 0; k < 10; k++) send_key(4'd1, 4'd0);
    check_val("t1_row_sat_hi", int'(cursor_i), 8);
    check_val("t1_col_still", int'(cursor_j), 0);
    for (int k = 0; k < 10; k++) send_key(4'd4, 4'd0);
    check_val("t1_col_sat_hi", int'(cursor_j), 8);
    check_val("t1_addr_80", int'(bus.cell_addr), 80);
    send_key(4'd3, 4'd0);
    send_key(4'd2, 4'd0);
    check_val("t1_row_7", int'(cursor_i), 7);
    check_val("t1_col_7", int'(cursor_j), 7);
    check_val("t1_addr_70", int'(bus.cell_addr), 70);
    send_key(4'd0, 4'd0);
    send_key(4'd7, 4'd0);
    check_val("t1_noop_busy", int'(busy), 0);
    check_val("t1_noop_addr", int'(bus.cell_addr), 70);
    for (int k = 0; k < 9; k++) send_key(4'd3, 4'd0);
    for (int k = 0; k < 9; k++) send_key(4'd2, 4'd0);
    check_val("t1_row_sat_lo", int'(cursor_i), 0);
    check_val("t1_col_sat_lo", int'(cursor_j), 0);
    check_val("t1_addr_0", int'(bus.cell_addr), 0);

    // ---- 2: write 7 into empty cell 0 ----
    mem_val[0] = 4'd0; mem_fixed[0] = 1'b0; wr_delay = 0;
    snap();
    send_key(4'd5, 4'd7);
    check_val("t2_rd_en_t1", int'(bus.rd_en), 1);
    check_val("t2_rd_cyc", rd_cyc - t_acc, 1);
    check_val("t2_key_ready_busy", int'(bus.key_ready), 0);
    step();
    check_val("t2_rd_en_t2", int'(bus.rd_en), 0);
    step();
    check_val("t2_wr_req_t3", int'(bus.wr_req), 1);
    check_val("t2_wr_data_t3", int'(bus.wr_data), 7);
    check_val("t2_count_pre", int'(filled_count), 0);
    step();
    check_val("t2_key_ready_t4", int'(bus.key_ready), 1);
    check_val("t2_count_post", int'(filled_count), 1);
    check_val("t2_rd_pulses", rd_cnt - r0, 1);
    check_val("t2_wr_cycles", wr_cnt - w0, 1);
    check_val("t2_rejects", rej_cnt - j0, 0);

    // ---- 3: clear on a fixed cell is refused ----
    mem_val[0] = 4'd7; mem_fixed[0] = 1'b1;
    snap();
    send_key(4'd6, 4'd0);
    step();
    check_val("t3_reject_t2", int'(reject), 0);
    step();
    check_val("t3_reject_t3", int'(reject), 1);
    check_val("t3_idle_t3", int'(busy), 0);
    step();
    check_val("t3_reject_t4", int'(reject), 0);
    check_val("t3_rej_cyc", rej_cyc - t_acc, 3);
    check_val("t3_no_write", wr_cnt - w0, 0);
    check_val("t3_count", int'(filled_count), 1);

    // ---- 4: same value is a silent no-op; delayed clear ----
    mem_val[0] = 4'd5; mem_fixed[0] = 1'b0;
    snap();
    send_key(4'd5, 4'd5);
    step();
    step();
    check_val("t4_same_idle", int'(busy), 0);
    check_val("t4_same_no_write", wr_cnt - w0, 0);
    check_val("t4_same_no_reject", rej_cnt - j0, 0);
    wr_delay = 3;
    snap();
    send_key(4'd6, 4'd0);
    step();
    step();
    check_val("t4_wr_req_t3", int'(bus.wr_req), 1);
    step();
    step();
    check_val("t4_count_t5", int'(filled_count), 1);
    step();
    check_val("t4_wr_ready_t6", int'(bus.wr_ready), 1);
    step();
    check_val("t4_wr_req_t7", int'(bus.wr_req), 0);
    check_val("t4_count_t7", int'(filled_count), 0);
    check_val("t4_wr_cycles", wr_cnt - w0, 4);
    check_val("t4_wr_first_cyc", wr_first_cyc - t_acc, 3);
    check_val("t4_wr_data", wr_first_data, 0);
    wr_delay = 0;

    // ---- 5: count_load priority, board full, saturation at CELLS ----
    step();
    count_load    = 1'b1;
    count_init    = 7'd80;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd4;
    #1;
    check_val("t5_ready_on_load", int'(bus.key_ready), 0);
    step();
    count_load    = 1'b0;
    bus.key_valid = 1'b0;
    check_val("t5_loaded", int'(filled_count), 80);
    check_val("t5_key_ignored", int'(cursor_j), 0);
    check_val("t5_not_full", int'(board_full), 0);
    mem_val[0] = 4'd0;
    send_key(4'd5, 4'd3);
    step();
    step();
    step();
    check_val("t5_count_81", int'(filled_count), 81);
    check_val("t5_full", int'(board_full), 1);
    mem_val[0] = 4'd3;
    snap();
    send_key(4'd5, 4'd4);
    wait_idle();
    check_val("t5_overwrite_wr", wr_cnt - w0, 1);
    check_val("t5_overwrite_cnt", int'(filled_count), 81);
    mem_val[0] = 4'd0;
    send_key(4'd5, 4'd9);
    wait_idle();
    check_val("t5_no_wrap", int'(filled_count), 81);

    // ---- 6: reset mid-write, then illegal digits ----
    send_key(4'd1, 4'd0);
    check_val("t6_addr_9", int'(bus.cell_addr), 9);
    mem_val[9] = 4'd0; mem_fixed[9] = 1'b0;
    wr_delay = 1000;
    send_key(4'd5, 4'd2);
    for (int k = 0; k < 10 && !bus.wr_req; k++) step();
    check_val("t6_wr_req_seen", int'(bus.wr_req), 1);
    reset_n = 1'b0;
    #1;
    check_val("t6_wr_req_drop", int'(bus.wr_req), 0);
    check_val("t6_idle", int'(busy), 0);
    check_val("t6_cursor_i", int'(cursor_i), 0);
    check_val("t6_count", int'(filled_count), 0);
    step();
    step();
    reset_n  = 1'b1;
    wr_delay = 0;
    snap();
    send_key(4'd5, 4'd0);
    check_val("t6_rej_d0", int'(reject), 1);
    check_val("t6_no_rd_d0", int'(bus.rd_en), 0);
    check_val("t6_busy_d0", int'(busy), 0);
    step();
    check_val("t6_rej_pulse_end", int'(reject), 0);
    send_key(4'd5, 4'd10);
    check_val("t6_rej_d10", int'(reject), 1);
    step();
    check_val("t6_rd_none", rd_cnt - r0, 0);
    check_val("t6_rej_total", rej_cnt - j0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
